// File: rtl/redmule_x_tile_scheduler.sv
// X-operand tile scheduler: walks the (row, w, col) tile loop nest, issues one
// address-generator request per tile and limits tiles in flight with credits.
module redmule_x_tile_scheduler #(
  parameter int unsigned DW        = 512,
  parameter int unsigned W         = 12,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_AHEAD = 2,
  localparam int unsigned LEN_W    = $clog2(W) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] x_addr_i,
  input  logic [ADDR_W-1:0] col_step_i,
  input  logic [ADDR_W-1:0] x_rows_offs_i,
  input  logic [ADDR_W-1:0] x_d1_stride_i,
  input  logic [CNT_W-1:0]  n_cols_i,
  input  logic [CNT_W-1:0]  n_w_i,
  input  logic [CNT_W-1:0]  n_rows_i,
  input  logic [7:0]        leftover_i,
  input  logic              mx_enable_i,
  input  logic              ready_start_i,
  input  logic              done_i,
  input  logic              consumed_i,
  output logic              req_start_o,
  output logic [ADDR_W-1:0] base_addr_o,
  output logic [ADDR_W-1:0] d1_stride_o,
  output logic [LEN_W-1:0]  tot_len_o,
  output logic [LEN_W-1:0]  d1_len_o,
  output logic              busy_o,
  output logic              finished_o,
  output logic              err_o
);

  localparam int unsigned CR_W = $clog2(MAX_AHEAD + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, DRAIN} state_e;

  // Handshake: a request is presented only when the source is ready and a
  // credit is free, so every cycle req_start_o is high is an accepted issue.
  state_e            state_q;
  logic [CR_W-1:0]   credits_q;
  logic              err_q;
  logic              finished_q;

  logic [ADDR_W-1:0] x_addr_q, col_step_q, rows_offs_q, d1_stride_q;
  logic [CNT_W-1:0]  n_cols_q, n_w_q, n_rows_q;
  logic [7:0]        leftover_q;
  logic              mx_q;

  logic [CNT_W-1:0]  col_q, w_q, row_q;
  logic [ADDR_W-1:0] col_offs_q, row_offs_q;

  logic col_last, w_last, row_last, tile_last, issue, zero_cfg;
  logic [8:0] n_tile;

  assign col_last  = (col_q == n_cols_q - CNT_W'(1));
  assign w_last    = (w_q == n_w_q - CNT_W'(1));
  assign row_last  = (row_q == n_rows_q - CNT_W'(1));
  assign tile_last = col_last && w_last && row_last;
  assign zero_cfg  = (n_cols_i == '0) || (n_w_i == '0) || (n_rows_i == '0);

  assign req_start_o = (state_q == ISSUE) && ready_start_i && (credits_q != '0);
  assign issue       = req_start_o;

  // Only the final row tile may be short; a leftover of 0 means a full tile.
  assign n_tile = (row_last && leftover_q != 8'd0) ? {1'b0, leftover_q} : 9'(W);

  assign base_addr_o = x_addr_q + row_offs_q + col_offs_q;
  assign tot_len_o   = mx_q ? LEN_W'((n_tile + 9'd1) >> 1) : LEN_W'(n_tile);
  assign d1_len_o    = mx_q ? LEN_W'(W >> 1) : LEN_W'(W);
  assign d1_stride_o = mx_q ? ADDR_W'(DW / 8) : d1_stride_q;
  assign busy_o      = (state_q != IDLE);
  assign finished_o  = finished_q;
  assign err_o       = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q     <= IDLE;
      credits_q   <= CR_W'(MAX_AHEAD);
      err_q       <= 1'b0;
      finished_q  <= 1'b0;
      x_addr_q    <= '0;
      col_step_q  <= '0;
      rows_offs_q <= '0;
      d1_stride_q <= '0;
      n_cols_q    <= '0;
      n_w_q       <= '0;
      n_rows_q    <= '0;
      leftover_q  <= '0;
      mx_q        <= 1'b0;
      col_q       <= '0;
      w_q         <= '0;
      row_q       <= '0;
      col_offs_q  <= '0;
      row_offs_q  <= '0;
    end else begin
      finished_q <= 1'b0;

      // A credit return with nothing outstanding is a protocol error.
      if (issue && !consumed_i) begin
        credits_q <= credits_q - CR_W'(1);
      end else if (consumed_i && !issue) begin
        if (credits_q == CR_W'(MAX_AHEAD)) err_q <= 1'b1;
        else credits_q <= credits_q + CR_W'(1);
      end

      case (state_q)
        IDLE: begin
          if (start_i) begin
            x_addr_q    <= x_addr_i;
            col_step_q  <= col_step_i;
            rows_offs_q <= x_rows_offs_i;
            d1_stride_q <= x_d1_stride_i;
            n_cols_q    <= n_cols_i;
            n_w_q       <= n_w_i;
            n_rows_q    <= n_rows_i;
            leftover_q  <= leftover_i;
            mx_q        <= mx_enable_i;
            state_q     <= zero_cfg ? DRAIN : ISSUE;
          end
        end
        ISSUE: begin
          if (issue) state_q <= RUN;
        end
        RUN: begin
          if (done_i) begin
            if (col_last) begin
              col_q      <= '0;
              col_offs_q <= '0;
              if (w_last) begin
                w_q <= '0;
                if (row_last) begin
                  row_q      <= '0;
                  row_offs_q <= '0;
                end else begin
                  row_q      <= row_q + CNT_W'(1);
                  row_offs_q <= row_offs_q + rows_offs_q;
                end
              end else begin
                w_q <= w_q + CNT_W'(1);
              end
            end else begin
              col_q      <= col_q + CNT_W'(1);
              col_offs_q <= col_offs_q + col_step_q;
            end
            state_q <= tile_last ? DRAIN : ISSUE;
          end
        end
        DRAIN: begin
          if (credits_q == CR_W'(MAX_AHEAD)) begin
            state_q    <= IDLE;
            finished_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/redmule_x_tile_scheduler.md
REDMULE_X_TILE_SCHEDULER -- requirements
Module: redmule_x_tile_scheduler

Interface
REQ-001 SHALL have parameter DW, default 512: memory beat width in bits; beat stride DW/8 bytes.
REQ-002 SHALL have parameter W, default 12: array width, i.e. maximum X rows (beats) per tile.
REQ-003 SHALL have parameter CNT_W, default 16: width of each iteration counter.
REQ-004 SHALL have parameter ADDR_W, default 32: byte address width.
REQ-005 SHALL have parameter MAX_AHEAD, default 2: maximum tiles issued but not yet consumed.
REQ-006 SHALL have ports, in this order:
- clk_i  in  1  clock; the block uses one clock
- rst_i  in  1  synchronous active-high reset
- clear_i  in  1  synchronous clear, same effect as rst_i
- start_i  in  1  single-cycle pulse; latches config and starts a job
- x_addr_i  in  ADDR_W  X base address
- col_step_i  in  ADDR_W  byte increment per column tile
- x_rows_offs_i  in  ADDR_W  byte increment per row tile
- x_d1_stride_i  in  ADDR_W  row stride in non-MX mode
- n_cols_i, n_w_i, n_rows_i  in  CNT_W each  loop counts (col innermost, rows outermost)
- leftover_i  in  8  valid rows in the last row tile; 0 means full
- mx_enable_i  in  1  packed-FP8 mode
- ready_start_i  in  1  stream source can accept a request
- done_i  in  1  stream source finished current tile
- consumed_i  in  1  downstream released one tile (credit return)
- req_start_o  out  1  tile request
- base_addr_o, d1_stride_o  out  ADDR_W  address-generator fields
- tot_len_o, d1_len_o  out  $clog2(W)+1  address-generator fields
- busy_o, finished_o, err_o  out  1  status

Function
REQ-007 SHALL latch all config inputs on start_i in IDLE; outputs use only latched values until the job ends.
REQ-008 SHALL ignore start_i outside IDLE.
REQ-009 SHALL implement FSM IDLE, ISSUE, RUN, DRAIN.
- IDLE -> ISSUE on start_i.
- ISSUE -> RUN on req_start_o && ready_start_i.
- RUN -> ISSUE on done_i when the tile is not last.
- RUN -> DRAIN on done_i when the tile is last.
- DRAIN -> IDLE when credits == MAX_AHEAD.
REQ-010 SHALL assert req_start_o = (state==ISSUE) && ready_start_i && (credits>0), combinationally.
REQ-011 SHALL initialise the credit counter to MAX_AHEAD:
- decrement on an issue handshake
- increment on consumed_i
- no change when both occur in the same cycle
REQ-012 SHALL, on consumed_i while credits==MAX_AHEAD with no same-cycle issue, keep credits unchanged and set sticky err_o.
REQ-013 SHALL advance the nested counters on done_i in RUN.
- col wraps at n_cols-1, then w increments.
- w wraps at n_w-1, then row increments.
- The tile is last when col==n_cols-1, w==n_w-1 and row==n_rows-1.
REQ-014 SHALL update offsets on the same done_i.
- col_offs += col_step, and returns to 0 when col wraps.
- row_offs += x_rows_offs when col and w both wrap.
- row_offs returns to 0 when row wraps.
REQ-015 SHALL drive base_addr_o = x_addr + row_offs + col_offs, modulo 2^ADDR_W.
REQ-016 SHALL compute n = leftover when row==n_rows-1 and leftover!=0, otherwise W.
- tot_len_o = (n+1)>>1 when mx_enable, else n.
REQ-017 SHALL drive d1_len_o = W>>1 when mx_enable, else W.
REQ-018 SHALL drive d1_stride_o = DW/8 when mx_enable, else x_d1_stride.
REQ-019 SHALL, when any of n_cols, n_w or n_rows is 0 at start_i, issue no request and pulse finished_o the next cycle; state returns to IDLE.
REQ-020 SHALL pulse finished_o for exactly one cycle on DRAIN->IDLE.
REQ-021 SHALL assert busy_o whenever state != IDLE.
REQ-022 SHALL ignore done_i outside RUN.

Reset
REQ-023 SHALL, on rst_i or clear_i, take effect at the next clk_i edge, including mid-job:
- state=IDLE, all counters and offsets 0, credits=MAX_AHEAD
- err_o, finished_o and busy_o deasserted
- latched config cleared to 0
REQ-024 SHALL give rst_i/clear_i priority over start_i, done_i and consumed_i in the same cycle.

Verification
REQ-025 SHALL cover: n_cols=2, n_w=1, n_rows=1, x_addr=0x1000, col_step=0x40, ready always 1, consumed after each done.
- Expect requests at base 0x1000 then 0x1040, each with tot_len=12.
- Expect one finished_o pulse.
REQ-026 SHALL cover: n_rows=2, n_cols=1, n_w=1, leftover=5, mx_enable=1, x_rows_offs=0x300.
- Tile 0: base x_addr, tot_len 6, d1_len 6, d1_stride 64.
- Tile 1: base x_addr+0x300, tot_len 3.
REQ-027 SHALL cover credit limit: MAX_AHEAD=2, 4 tiles, consumed_i withheld.
- Exactly 2 requests issue, then the FSM stalls in ISSUE.
- Each consumed pulse releases one more request.
- finished_o follows the final consumed.
REQ-028 SHALL cover: start with n_w=0.
- No req_start_o; finished_o high exactly one cycle later; busy_o high for one cycle.
REQ-029 SHALL cover: rst_i asserted in RUN after 1 of 3 tiles.
- Next cycle: busy_o=0, credits back to full.
- A fresh start_i restarts at base x_addr.
REQ-030 SHALL cover: consumed_i in IDLE with credits full.
- err_o=1 and stays set until rst_i or clear_i.
